// File: rtl/hbridge_overcurrent_guard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hbridge_overcurrent_guard: per-side over-current trip/cooldown/lockout     |
// | gating of H-bridge enable and polarity, with shoot-through blocking.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module hbridge_overcurrent_guard #(
  parameter int FILTER_CYCLES   = 100,
  parameter int COOLDOWN_CYCLES = 50_000_000,
  parameter int MAX_RETRIES     = 3,
  parameter int HEAL_CYCLES     = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       oc_left_n,
  input  logic       oc_right_n,
  input  logic       clear,
  input  logic       en_left_in,
  input  logic       en_right_in,
  input  logic [3:0] pol_in,
  output logic       en_left_out,
  output logic       en_right_out,
  output logic [3:0] pol_out,
  output logic       fault_left,
  output logic       fault_right,
  output logic       lockout_left,
  output logic       lockout_right
);

  localparam int c_flt_w   = (FILTER_CYCLES   > 1) ? $clog2(FILTER_CYCLES)   : 1;
  localparam int c_cool_w  = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam int c_heal_w  = (HEAL_CYCLES     > 1) ? $clog2(HEAL_CYCLES)     : 1;
  localparam int c_retry_w = $clog2(MAX_RETRIES + 1);

  localparam logic [c_flt_w-1:0]   c_flt_max   = c_flt_w'(FILTER_CYCLES - 1);
  localparam logic [c_cool_w-1:0]  c_cool_max  = c_cool_w'(COOLDOWN_CYCLES - 1);
  localparam logic [c_heal_w-1:0]  c_heal_max  = c_heal_w'(HEAL_CYCLES - 1);
  localparam logic [c_retry_w-1:0] c_retry_max = c_retry_w'(MAX_RETRIES - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_COOL = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  // Side index 0 = right (pol bits [1:0]), 1 = left (pol bits [3:2]).
  logic [1:0] w_oc_n;
  logic [1:0] w_en_in;
  logic [1:0] w_en_out;
  logic [1:0] w_fault;
  logic [1:0] w_lock;

  assign w_oc_n  = {oc_left_n, oc_right_n};
  assign w_en_in = {en_left_in, en_right_in};

  for (genvar s = 0; s < 2; s++) begin : g_side
    logic                 sync1_q, sync2_q;
    logic [c_flt_w-1:0]   flt_q, flt_d;
    logic [c_cool_w-1:0]  cool_q, cool_d;
    logic [c_heal_w-1:0]  heal_q, heal_d;
    logic [c_retry_w-1:0] retry_q, retry_d;
    state_t               state_q, state_d;
    logic                 en_q, en_d;
    logic [1:0]           pol_q, pol_d;
    logic                 fault_q, lock_q;
    logic                 w_oc, w_trip, w_fwd, w_back, w_pass;

    assign w_oc   = ~sync2_q;
    assign w_trip = w_oc & (flt_q == c_flt_max);
    assign w_fwd  = pol_in[2*s];
    assign w_back = pol_in[2*s+1];

    always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      cool_d  = cool_q;
      heal_d  = '0;
      flt_d   = !w_oc ? '0 : ((flt_q == c_flt_max) ? flt_q : flt_q + 1'b1);
      case (state_q)
        ST_RUN: begin
          // A trip takes precedence over a heal landing on the same cycle.
          if (w_trip) begin
            if (retry_q == c_retry_max) begin
              state_d = ST_LOCK;
              retry_d = '0;
            end else begin
              state_d = ST_COOL;
              retry_d = retry_q + 1'b1;
              cool_d  = '0;
            end
          end else if (heal_q == c_heal_max) begin
            retry_d = '0;
          end else begin
            heal_d = heal_q + 1'b1;
          end
        end
        ST_COOL: begin
          if (cool_q == c_cool_max) begin
            state_d = ST_RUN;
            flt_d   = '0;
          end else begin
            cool_d = cool_q + 1'b1;
          end
        end
        ST_LOCK: begin
          if (clear) begin
            state_d = ST_RUN;
            flt_d   = '0;
            retry_d = '0;
          end
        end
        default: state_d = ST_RUN;
      endcase
      // Drive only while in RUN on both sides of the edge and never with both legs on.
      w_pass = (state_q == ST_RUN) && (state_d == ST_RUN) && !(w_fwd && w_back);
      en_d   = w_pass && w_en_in[s];
      pol_d  = w_pass ? {w_back, w_fwd} : 2'b00;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        flt_q   <= '0;
        cool_q  <= '0;
        heal_q  <= '0;
        retry_q <= '0;
        state_q <= ST_RUN;
        en_q    <= 1'b0;
        pol_q   <= 2'b00;
        fault_q <= 1'b0;
        lock_q  <= 1'b0;
      end else begin
        sync1_q <= w_oc_n[s];
        sync2_q <= sync1_q;
        flt_q   <= flt_d;
        cool_q  <= cool_d;
        heal_q  <= heal_d;
        retry_q <= retry_d;
        state_q <= state_d;
        en_q    <= en_d;
        pol_q   <= pol_d;
        fault_q <= (state_d != ST_RUN);
        lock_q  <= (state_d == ST_LOCK);
      end
    end

    assign w_en_out[s]    = en_q;
    assign pol_out[2*s+:2] = pol_q;
    assign w_fault[s]     = fault_q;
    assign w_lock[s]      = lock_q;
  end

  assign en_left_out   = w_en_out[1];
  assign en_right_out  = w_en_out[0];
  assign fault_left    = w_fault[1];
  assign fault_right   = w_fault[0];
  assign lockout_left  = w_lock[1];
  assign lockout_right = w_lock[0];

endmodule
`default_nettype wire

// File: tb/tb_hbridge_overcurrent_guard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hbridge_overcurrent_guard: directed bench with an expected-output queue |
// | Rev 1.1                                                                    |
// +----------------------------------------------------------------------------+
module tb_hbridge_overcurrent_guard;

    logic       clk = 1'b0;
    logic       rst;
    logic       r_oc_left_n, r_oc_right_n, r_clear;
    logic       r_en_left_in, r_en_right_in;
    logic [3:0] r_pol_in;
    logic       w_en_left_out, w_en_right_out;
    logic [3:0] w_pol_out;
    logic       w_fault_left, w_fault_right, w_lockout_left, w_lockout_right;

    hbridge_overcurrent_guard #(
        .FILTER_CYCLES  (4),
        .COOLDOWN_CYCLES(20),
        .MAX_RETRIES    (2),
        .HEAL_CYCLES    (50)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .oc_left_n    (r_oc_left_n),
        .oc_right_n   (r_oc_right_n),
        .clear        (r_clear),
        .en_left_in   (r_en_left_in),
        .en_right_in  (r_en_right_in),
        .pol_in       (r_pol_in),
        .en_left_out  (w_en_left_out),
        .en_right_out (w_en_right_out),
        .pol_out      (w_pol_out),
        .fault_left   (w_fault_left),
        .fault_right  (w_fault_right),
        .lockout_left (w_lockout_left),
        .lockout_right(w_lockout_right)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } sb_t;

    sb_t        r_sb_q[$];
    sb_t        r_cur;
    int         r_checks   = 0;
    int         r_failures = 0;
    logic [9:0] w_obs;

    // {en_l, en_r, pol[3:0], fault_l, fault_r, lock_l, lock_r}
    assign w_obs = {w_en_left_out, w_en_right_out, w_pol_out, w_fault_left, w_fault_right,
                    w_lockout_left, w_lockout_right};

    function automatic logic [9:0] o(input logic el, input logic er, input logic [3:0] p,
                                     input logic fl, input logic fr,
                                     input logic ll, input logic lr);
        return {el, er, p, fl, fr, ll, lr};
    endfunction

    localparam logic [9:0] c_P      = 10'b11_0101_0000;
    localparam logic [9:0] c_L_COOL = 10'b01_0001_1000;
    localparam logic [9:0] c_L_LOCK = 10'b01_0001_1010;
    localparam logic [9:0] c_L_GATE = 10'b01_0001_0000;
    localparam int         c_DIRECT = 6;

    task automatic tick(input string tag, input logic [9:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        r_sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (r_sb_q.size() != 0) begin
                r_cur = r_sb_q.pop_front();
                r_checks++;
                assert (w_obs === r_cur.exp) else begin
                    r_failures++;
                    $error("FAIL %s observed=%b expected=%b", r_cur.tag, w_obs, r_cur.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", r_checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; r_oc_left_n = 1'b1; r_oc_right_n = 1'b1; r_clear = 1'b0;
        r_en_left_in = 1'b0; r_en_right_in = 1'b0; r_pol_in = 4'b0000;
        #1;
        repeat (2) tick("reset", 10'b0);

        rst = 1'b0; r_en_left_in = 1'b1; r_en_right_in = 1'b1; r_pol_in = 4'b0101;
        repeat (2) tick("pass", c_P);

        r_oc_left_n = 1'b0;
        repeat (3) tick("short_oc", c_P);
        r_oc_left_n = 1'b1;
        repeat (6) tick("short_oc_after", c_P);

        r_oc_left_n = 1'b0;
        repeat (5) tick("pre_trip", c_P);
        tick("trip1", c_L_COOL);
        r_checks++;
        if (w_fault_left !== 1'b1 || w_en_left_out !== 1'b0 || w_en_right_out !== 1'b1) begin
            r_failures++;
            $error("FAIL trip1_direct fault_l=%b en_l=%b en_r=%b",
                   w_fault_left, w_en_left_out, w_en_right_out);
        end
        r_oc_left_n = 1'b1;

        repeat (19) tick("cool", c_L_COOL);
        tick("cool_exit", c_L_GATE);
        tick("resume", c_P);

        r_oc_left_n = 1'b0;
        repeat (4) tick("pre_trip2", c_P);
        r_oc_left_n = 1'b1;
        tick("pre_trip2_b", c_P);
        tick("lock", c_L_LOCK);
        repeat (25) tick("lock_hold", c_L_LOCK);
        r_checks++;
        if (w_lockout_left !== 1'b1) begin
            r_failures++;
            $error("FAIL lock_hold_direct lockout_l=%b", w_lockout_left);
        end
        r_clear = 1'b1;
        tick("clear", c_L_GATE);
        r_checks++;
        if (w_lockout_left !== 1'b0) begin
            r_failures++;
            $error("FAIL clear_direct lockout_l=%b", w_lockout_left);
        end
        r_clear = 1'b0;
        tick("after_clear", c_P);

        r_pol_in = 4'b1100;
        tick("shoot_left", o(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
        r_checks++;
        if (w_pol_out[3:2] !== 2'b00 || w_fault_left !== 1'b0) begin
            r_failures++;
            $error("FAIL shoot_direct pol=%b fault_l=%b", w_pol_out, w_fault_left);
        end
        r_pol_in = 4'b0011;
        tick("shoot_right", o(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
        r_pol_in = 4'b0101; r_en_left_in = 1'b0;
        tick("en_left_low", o(1'b0, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0));
        r_en_left_in = 1'b1;
        tick("en_left_high", c_P);

        r_oc_left_n = 1'b0;
        repeat (4) tick("pre_trip3", c_P);
        r_oc_left_n = 1'b1;
        tick("pre_trip3_b", c_P);
        tick("trip3", c_L_COOL);
        repeat (19) tick("cool3", c_L_COOL);
        tick("cool3_exit", c_L_GATE);
        repeat (60) tick("heal_run", c_P);
        r_oc_left_n = 1'b0;
        repeat (4) tick("pre_trip4", c_P);
        r_oc_left_n = 1'b1;
        tick("pre_trip4_b", c_P);
        tick("trip4_healed", c_L_COOL);
        repeat (3) tick("cool4", c_L_COOL);

        rst = 1'b1;
        tick("rst_mid_cool", 10'b0);
        r_checks++;
        if (w_obs !== 10'b0) begin
            r_failures++;
            $error("FAIL rst_direct observed=%b", w_obs);
        end
        rst = 1'b0;
        tick("after_rst", c_P);
        r_checks++;
        if (w_fault_left !== 1'b0 || w_en_left_out !== 1'b1) begin
            r_failures++;
            $error("FAIL after_rst_direct fault_l=%b en_l=%b", w_fault_left, w_en_left_out);
        end

        @(negedge clk);
        #1;
        if (r_checks <= c_DIRECT) begin
            r_failures++;
            $error("FAIL scoreboard never compared checks=%0d", r_checks);
        end
        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
        $finish;
    end

endmodule
`default_nettype wire
